// File: rtl/block_dispatcher_pkg.sv
// ============================================================================
//  block_dispatcher_pkg
//  Shared block/instruction types, grid geometry and dispatch-state encoding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package block_dispatcher_pkg;

  localparam int c_BLOCK_SIZE = 128;
  localparam int c_NUM_ROWS   = 4;
  localparam int c_NUM_COLS   = 4;
  localparam int c_SLOTS      = 8;

  localparam logic [6:0] c_OP_NOP = 7'h00;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [24:0] operands;
  } instr_t;

  typedef struct packed {
    logic [7:0]  blk_id;
    logic [23:0] flags;
  } block_header_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DONE     = 2'd2
  } disp_state_e;

  function automatic logic is_nop(input instr_t ins);
    return ins.opcode == c_OP_NOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/block_dispatcher_row_lane.sv
// ============================================================================
//  dispatch_row_lane
//  One E-grid row: pending mask, lowest-set-bit select and handshake clear.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dispatch_row_lane #(
  parameter int ROW_LEN = 32,
  parameter int IDX_W   = $clog2(ROW_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [ROW_LEN-1:0] i_load_mask,
  input  logic               i_flush,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_empty
);

  logic [ROW_LEN-1:0] r_mask;
  logic [IDX_W-1:0]   w_idx;
  logic               w_hs;

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    w_idx = '0;
    for (int k = ROW_LEN - 1; k >= 0; k--) begin
      if (r_mask[k]) begin
        w_idx = IDX_W'(k);
      end
    end
  end

  assign o_valid = |r_mask;
  assign o_empty = ~o_valid;
  assign o_idx   = w_idx;
  assign w_hs    = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (i_flush) begin
      r_mask <= '0;
    end else if (i_load) begin
      r_mask <= i_load_mask;
    end else if (w_hs) begin
      r_mask[w_idx] <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/block_dispatcher.sv
// ============================================================================
//  block_dispatcher
//  Latches a decoded hyperblock and streams it to the E-grid, one bus per row.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module block_dispatcher
  import block_dispatcher_pkg::*;
#(
  parameter int  BLOCK_SIZE = c_BLOCK_SIZE,
  parameter int  NUM_ROWS   = c_NUM_ROWS,
  parameter int  NUM_COLS   = c_NUM_COLS,
  parameter int  SLOTS      = c_SLOTS,
  parameter bit  SKIP_NOPS  = 1'b1,
  localparam int ROW_LEN    = NUM_COLS * SLOTS,
  localparam int IDX_W      = $clog2(ROW_LEN),
  localparam int COL_W      = $clog2(NUM_COLS),
  localparam int SLOT_W     = $clog2(SLOTS),
  localparam int BUF_W      = $clog2(BLOCK_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_blk_valid,
  input  instr_t                           i_blk_instructions [BLOCK_SIZE],
  input  block_header_t                    i_blk_header,
  input  logic                             i_flush,
  output logic                             o_blk_accept,
  output logic                             o_busy,
  output logic                             o_blk_overrun,
  output logic [NUM_ROWS-1:0]              o_row_valid,
  output instr_t [NUM_ROWS-1:0]            o_row_instr,
  output logic [NUM_ROWS-1:0][COL_W-1:0]   o_row_col,
  output logic [NUM_ROWS-1:0][SLOT_W-1:0]  o_row_slot,
  input  logic [NUM_ROWS-1:0]              i_row_ready,
  output logic                             o_dispatch_done,
  output block_header_t                    o_done_header
);

  disp_state_e   r_state;
  disp_state_e   w_next;
  instr_t        r_buf [BLOCK_SIZE];
  block_header_t r_header;
  logic          r_overrun;
  logic          w_accept;
  logic [NUM_ROWS-1:0] w_empty;

  assign w_accept = (r_state == ST_IDLE) & i_blk_valid & ~i_flush;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_next = ST_DISPATCH;
      ST_DISPATCH: if (&w_empty) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    if (i_flush) begin
      w_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        r_buf[i] <= '0;
      end
      r_header <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        r_buf[i] <= i_blk_instructions[i];
      end
      r_header <= i_blk_header;
    end
  end

  // A block offered while busy is dropped; the flag stays up until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (i_blk_valid && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_blk_accept    = w_accept;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_blk_overrun   = r_overrun;
  assign o_dispatch_done = (r_state == ST_DONE);
  assign o_done_header   = (r_state == ST_DONE) ? r_header : '0;

  generate
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
      localparam logic [BUF_W-1:0] c_BASE = BUF_W'(r * ROW_LEN);

      logic [ROW_LEN-1:0] w_load_mask;
      logic               w_valid;
      logic [IDX_W-1:0]   w_idx;
      logic [BUF_W-1:0]   w_buf_idx;

      always_comb begin
        w_load_mask = '0;
        for (int k = 0; k < ROW_LEN; k++) begin
          w_load_mask[k] = !SKIP_NOPS || !is_nop(i_blk_instructions[r * ROW_LEN + k]);
        end
      end

      dispatch_row_lane #(
        .ROW_LEN (ROW_LEN),
        .IDX_W   (IDX_W)
      ) u_lane (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_load_mask (w_load_mask),
        .i_flush     (i_flush),
        .i_ready     (i_row_ready[r]),
        .o_valid     (w_valid),
        .o_idx       (w_idx),
        .o_empty     (w_empty[r])
      );

      // Lane index splits into column (upper bits) and slot (lower bits).
      assign w_buf_idx      = c_BASE + BUF_W'(w_idx);
      assign o_row_valid[r] = w_valid;
      assign o_row_instr[r] = w_valid ? r_buf[w_buf_idx] : '0;
      assign o_row_col[r]   = w_idx[IDX_W-1 -: COL_W];
      assign o_row_slot[r]  = w_idx[SLOT_W-1:0];
    end
  endgenerate

endmodule

`default_nettype wire
